video_timing_gen: RTL and testbench

Source end of the video pixel interface consumed by the overlay/UUT stage. Generates 1080p60 raster timing (`vh_blank_o`, `dvh_sync_o`), aligned pixel coordinates, a start-of-frame strobe, and an optional scrolling colour-bar test pattern on `vid_rgb_o`. Advances one pixel per `cen_i` cycle. Drives the overlay stage's `vid_rgb_i` / `vh_blank_i` / `dvh_sync_i` inputs directly.

---
 rtl/video_timing_gen.sv | 101 ++++++++++
 tb/tb_video_timing_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing, aligned coordinates, SOF strobe and frame counter for the pixel interface.
// Define VTG_PATTERN_EN to replace the flat grey fill with scrolling colour bars.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int SYNC_POL = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] hcount_o,
  output logic [11:0] vcount_o,
  output logic        sof_o,
  output logic [15:0] frame_cnt_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
  localparam logic [11:0] VT_M1 = 12'(V_TOTAL - 1);
  localparam logic [11:0] HS0   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS0   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SP    = SYNC_POL != 0;

  logic [11:0] h_cnt, v_cnt;
  logic        h_blank, v_blank, h_sync, v_sync, d_sync, sof;
  logic [23:0] rgb;

  always_comb begin
    h_blank = h_cnt >= HA;
    v_blank = v_cnt >= VA;
    h_sync  = h_cnt >= HS0 && h_cnt < HS1;
    v_sync  = v_cnt >= VS0 && v_cnt < VS1;
    d_sync  = ~h_blank & ~v_blank;
    sof     = h_cnt == '0 && v_cnt == '0;
  end

  // the line counter steps on the Hblank rising edge so Vblank/Vsync move together with Hblank
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt_o <= '0;
    end else if (cen_i) begin
      h_cnt <= h_cnt == HT_M1 ? '0 : h_cnt + 12'd1;
      if (h_cnt == HA - 12'd1) v_cnt <= v_cnt == VT_M1 ? '0 : v_cnt + 12'd1;
      if (sof) frame_cnt_o <= frame_cnt_o + 16'd1;
    end
  end

`ifdef VTG_PATTERN_EN
  localparam logic [11:0] BW = 12'(H_ACTIVE / 8);
  logic [11:0] scroll, pos, bar_q;
  logic [12:0] pos_sum;
  logic [2:0]  bar;
  // scroll advances on the frame wrap so every pixel of a frame shares one offset
  always_ff @(posedge clk_i) begin
    if (rst_i) scroll <= '0;
    else if (cen_i && h_cnt == HT_M1 && v_cnt == VT_M1) scroll <= scroll == HA - 12'd1 ? '0 : scroll + 12'd1;
  end
  always_comb begin
    pos_sum = {1'b0, h_cnt} + {1'b0, scroll};
    pos     = pos_sum >= {1'b0, HA} ? 12'(pos_sum - {1'b0, HA}) : pos_sum[11:0];
    bar_q   = pos / BW;
    bar     = bar_q > 12'd7 ? 3'd7 : bar_q[2:0];
    rgb     = d_sync ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : '0;
  end
`else
  always_comb rgb = d_sync ? 24'h808080 : '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vh_blank_o <= 2'b11;
      dvh_sync_o <= {1'b0, ~SP, ~SP};
      vid_rgb_o  <= '0;
      hcount_o   <= '0;
      vcount_o   <= '0;
      sof_o      <= 1'b0;
    end else if (cen_i) begin
      vh_blank_o <= {v_blank, h_blank};
      dvh_sync_o <= {d_sync, v_sync ~^ SP, h_sync ~^ SP};
      vid_rgb_o  <= rgb;
      hcount_o   <= h_cnt;
      vcount_o   <= v_cnt;
      sof_o      <= sof;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: checks two small-raster instances (sync polarity 1 and 0) against a per-pixel arithmetic model.
module tb_video_timing_gen;
  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;

  logic clk_i = 1'b0, rst_i = 1'b1, cen_i = 1'b0;
  logic [1:0] vhb_a, vhb_b;
  logic [2:0] dvh_a, dvh_b;
  logic [23:0] rgb_a, rgb_b;
  logic [11:0] hc_a, hc_b, vc_a, vc_b;
  logic sof_a, sof_b;
  logic [15:0] fc_a, fc_b;
  int total = 0, bad = 0, n = -1;

  always #5 clk_i = ~clk_i;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1)) dut_a (.clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i),
    .vh_blank_o(vhb_a), .dvh_sync_o(dvh_a), .vid_rgb_o(rgb_a), .hcount_o(hc_a), .vcount_o(vc_a),
    .sof_o(sof_a), .frame_cnt_o(fc_a));
  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
    .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(0)) dut_b (.clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i),
    .vh_blank_o(vhb_b), .dvh_sync_o(dvh_b), .vid_rgb_o(rgb_b), .hcount_o(hc_b), .vcount_o(vc_b),
    .sof_o(sof_b), .frame_cnt_o(fc_b));

`ifdef VTG_PATTERN_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  function automatic int h_of(input int p);
    return p % HT;
  endfunction
  // a line is blanking then active, so the line number flips HT-HA pixels before h wraps
  function automatic int v_of(input int p);
    return ((p + HT - HA) / HT) % VT;
  endfunction

  // {vblank,hblank, de,vsync,hsync, rgb, hcount, vcount, sof} for pixel p; p<0 means reset state
  function automatic logic [53:0] model(input int p);
    int h, v;
    logic hb, vb, hs, vs, de;
    logic [23:0] rgb;
    if (p < 0) return {2'b11, 3'b000, 24'h0, 12'h0, 12'h0, 1'b0};
    h = h_of(p);
    v = v_of(p);
    hb = h >= HA;
    vb = v >= VA;
    hs = h >= HA + HFP && h < HA + HFP + HSW;
    vs = v >= VA + VFP && v < VA + VFP + VSW;
    de = !hb && !vb;
    rgb = 24'h0;
`ifdef VTG_PATTERN_EN
    begin
      int f, bi;
      f = (p / FR) % HA;
      bi = ((h + f) % HA) / (HA / 8);
      if (bi > 7) bi = 7;
      if (de) rgb = bars[bi];
    end
`else
    if (de) rgb = 24'h808080;
`endif
    return {vb, hb, de, vs, hs, rgb, 12'(h), 12'(v), h == 0 && v == 0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit c);
    logic [53:0] e;
    @(negedge clk_i);
    rst_i = r;
    cen_i = c;
    @(posedge clk_i);
    #1;
    if (r) n = -1;
    else if (c) n++;
    e = model(n);
    chk("pos_pol", 64'({vhb_a, dvh_a, rgb_a, hc_a, vc_a, sof_a}), 64'(e));
    chk("neg_pol", 64'({vhb_b, dvh_b, rgb_b, hc_b, vc_b, sof_b}), 64'(e ^ (54'd3 << 49)));
    chk("frame_cnt", 64'(fc_a), n < 0 ? 64'd0 : 64'(16'(n / FR + 1)));
    chk("frame_cnt_b", 64'(fc_b), n < 0 ? 64'd0 : 64'(16'(n / FR + 1)));
  endtask

  initial begin
    bit found;
    cyc(1, 1);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    for (int i = 0; i < 2 * FR + 40; i++) cyc(0, 1);
    for (int i = 0; i < 400; i++) cyc(0, 1'($urandom_range(0, 1)));
    found = 0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      cyc(0, 1);
      found = v_of(n) == 2 && h_of(n) == 5;
    end
    chk("reach_line2", 64'(found), 64'd1);
    cyc(1, 0);
    chk("rst_blank", 64'(vhb_a), 64'd3);
    chk("rst_sync", 64'(dvh_a), 64'd0);
    cyc(0, 1);
    chk("post_rst_sof", 64'({sof_a, hc_a, vc_a}), 64'({1'b1, 24'h0}));
    for (int i = 0; i < FR + 30; i++) cyc(0, 1);
    for (int i = 0; i < 200; i++) cyc(0, 1'($urandom_range(0, 3) != 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
